// File: rtl/hpi_pkg.sv
// Shared constants for the HPI responder: register selects and STATUS bit positions.
// Latency: n/a (package).
// Backpressure: n/a (package).
package hpi_pkg;

    // Register select values carried on hpi_addr.
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    // STATUS register bit positions.
    localparam int STAT_ERR      = 15;  // sticky: r_n and w_n both asserted under cs_n
    localparam int STAT_OVR      = 14;  // sticky: inbound mailbox word overwritten
    localparam int STAT_IN_VLD   = 1;   // inbound mailbox word pending for local logic
    localparam int STAT_OUT_FULL = 0;   // outbound mailbox word waiting for the SoC

endpackage

// File: rtl/hpi_strobe_edge.sv
// Qualified HPI strobe edge detector: one-cycle pulse on the first cycle of a read or write access.
// Latency: combinational pulse in the first cycle the act signal is high; history is one flop per act.
// Backpressure: none; a strobe held for many cycles yields exactly one pulse.
//
// Ports: clk/rst_n clock and async active-low reset; rd_act/wr_act qualified access levels;
//        rd_edge/wr_edge single-cycle rising-edge pulses.
module hpi_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_act,
    input  logic wr_act,
    output logic rd_edge,
    output logic wr_edge
);

    logic rd_act_q, rd_act_d;
    logic wr_act_q, wr_act_d;

    always_comb begin
        rd_act_d = rd_act;
        wr_act_d = wr_act;
    end

    // Cleared by reset so a strobe held across reset release is seen as a new access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_act_q <= 1'b0;
            wr_act_q <= 1'b0;
        end else begin
            rd_act_q <= rd_act_d;
            wr_act_q <= wr_act_d;
        end
    end

    assign rd_edge = rd_act & ~rd_act_q;
    assign wr_edge = wr_act & ~wr_act_q;

endmodule

// File: rtl/hpi_responder.sv
// HPI target for the SoC PIO master: word RAM with auto-incrementing pointer, two mailboxes, STATUS.
// Latency: writes commit on the first strobe cycle; hpi_rdata is registered, valid one edge after it.
// Backpressure: local RAM writes stall (loc_wr_ready=0) under an HPI DATA write; mailboxes valid/ready.
//
// Ports: clk_clk/reset_reset_n clock and async active-low reset;
//        hpi_* SoC strobe bus (cs/r/w active low, 2-bit register select, 16-bit data each way);
//        loc_wr_* local RAM write port; mbx_in_* SoC->local mailbox; mbx_out_* local->SoC mailbox.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic          hpi_cs_n,
    input  logic          hpi_r_n,
    input  logic          hpi_w_n,
    input  logic [1:0]    hpi_addr,
    input  logic [15:0]   hpi_wdata,
    output logic [15:0]   hpi_rdata,
    input  logic          loc_wr_en,
    input  logic [AW-1:0] loc_wr_addr,
    input  logic [15:0]   loc_wr_data,
    output logic          loc_wr_ready,
    output logic [15:0]   mbx_in_data,
    output logic          mbx_in_valid,
    input  logic          mbx_in_ready,
    input  logic [15:0]   mbx_out_data,
    input  logic          mbx_out_valid,
    output logic          mbx_out_ready
);

    logic rd_act, wr_act, illegal;
    logic rd_edge, wr_edge, wr_data_edge;

    logic [15:0]   rdata_q, rdata_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   in_data_q, in_data_d;
    logic          in_vld_q, in_vld_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_full_q, out_full_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_q [RAM_WORDS];

    logic          post_acc;
    logic [15:0]   status_word;

    assign rd_act  = ~hpi_cs_n & ~hpi_r_n &  hpi_w_n;
    assign wr_act  = ~hpi_cs_n & ~hpi_w_n &  hpi_r_n;
    assign illegal = ~hpi_cs_n & ~hpi_r_n & ~hpi_w_n;

    hpi_strobe_edge u_edge (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .rd_act  (rd_act),
        .wr_act  (wr_act),
        .rd_edge (rd_edge),
        .wr_edge (wr_edge)
    );

    assign wr_data_edge = wr_edge & (hpi_addr == HPI_DATA);

    // HPI DATA write owns the single RAM write port; the local side retries.
    // Gated by reset so nothing is granted or written while the block is held in reset.
    assign loc_wr_ready  = loc_wr_en & ~wr_data_edge & reset_reset_n;
    assign mbx_out_ready = ~out_full_q;
    assign post_acc      = mbx_out_valid & ~out_full_q;

    assign status_word = {err_q, ovr_q, 12'b0, in_vld_q, out_full_q};

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = loc_wr_addr;
        ram_wdata = loc_wr_data;
        if (wr_data_edge && reset_reset_n) begin
            ram_we    = 1'b1;
            ram_waddr = ptr_q;
            ram_wdata = hpi_wdata;
        end else if (loc_wr_ready) begin
            ram_we    = 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (ram_we) begin
            ram_q[ram_waddr] <= ram_wdata;
        end
    end

    always_comb begin
        rdata_d    = rdata_q;
        ptr_d      = ptr_q;
        in_data_d  = in_data_q;
        in_vld_d   = in_vld_q;
        out_data_d = out_data_q;
        out_full_d = out_full_q;
        err_d      = err_q;
        ovr_d      = ovr_q;

        // Local consumer handshake; a same-cycle SoC write below re-arms valid.
        if (in_vld_q && mbx_in_ready) begin
            in_vld_d = 1'b0;
        end

        if (wr_edge) begin
            case (hpi_addr)
                HPI_DATA: ptr_d = ptr_q + 1'b1;
                HPI_MAILBOX: begin
                    // Only an overwrite if the pending word is not being taken this cycle.
                    if (in_vld_q && !mbx_in_ready) begin
                        ovr_d = 1'b1;
                    end
                    in_data_d = hpi_wdata;
                    in_vld_d  = 1'b1;
                end
                HPI_ADDR: ptr_d = hpi_wdata[AW:1];
                default: ;
            endcase
        end

        if (rd_edge) begin
            case (hpi_addr)
                HPI_DATA: begin
                    rdata_d = ram_q[ptr_q];
                    ptr_d   = ptr_q + 1'b1;
                end
                HPI_MAILBOX: begin
                    rdata_d    = out_data_q;
                    out_full_d = 1'b0;
                end
                HPI_ADDR: rdata_d = 16'({ptr_q, 1'b0});
                default: begin
                    rdata_d = status_word;
                    err_d   = 1'b0;
                    ovr_d   = 1'b0;
                end
            endcase
        end

        // Accepted only when empty, so it never races a MAILBOX read that clears a full slot.
        if (post_acc) begin
            out_data_d = mbx_out_data;
            out_full_d = 1'b1;
        end

        if (illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rdata_q    <= '0;
            ptr_q      <= '0;
            in_data_q  <= '0;
            in_vld_q   <= 1'b0;
            out_data_q <= '0;
            out_full_q <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            ptr_q      <= ptr_d;
            in_data_q  <= in_data_d;
            in_vld_q   <= in_vld_d;
            out_data_q <= out_data_d;
            out_full_q <= out_full_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign hpi_rdata    = rdata_q;
    assign mbx_in_data  = in_data_q;
    assign mbx_in_valid = in_vld_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: directed scenarios then random traffic vs. a behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_hpi_responder;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        hpi_cs_n, hpi_r_n, hpi_w_n;
    logic [1:0]  hpi_addr;
    logic [15:0] hpi_wdata, hpi_rdata;
    logic        loc_wr_en, loc_wr_ready;
    logic [7:0]  loc_wr_addr;
    logic [15:0] loc_wr_data;
    logic [15:0] mbx_in_data, mbx_out_data;
    logic        mbx_in_valid, mbx_in_ready, mbx_out_valid, mbx_out_ready;

    always #5 clk_clk = ~clk_clk;

    hpi_responder #(.RAM_WORDS(256), .AW(8)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .hpi_cs_n      (hpi_cs_n),
        .hpi_r_n       (hpi_r_n),
        .hpi_w_n       (hpi_w_n),
        .hpi_addr      (hpi_addr),
        .hpi_wdata     (hpi_wdata),
        .hpi_rdata     (hpi_rdata),
        .loc_wr_en     (loc_wr_en),
        .loc_wr_addr   (loc_wr_addr),
        .loc_wr_data   (loc_wr_data),
        .loc_wr_ready  (loc_wr_ready),
        .mbx_in_data   (mbx_in_data),
        .mbx_in_valid  (mbx_in_valid),
        .mbx_in_ready  (mbx_in_ready),
        .mbx_out_data  (mbx_out_data),
        .mbx_out_valid (mbx_out_valid),
        .mbx_out_ready (mbx_out_ready)
    );

    // Behavioural model of the register file as the SoC sees it.
    logic [15:0] m_mem [256];
    int          m_ptr;
    bit          m_in_pend, m_ovr, m_err, m_out_full;
    logic [15:0] m_in_word, m_out_word;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s = 16'h0000;
        s[15] = m_err;
        s[14] = m_ovr;
        s[1]  = m_in_pend;
        s[0]  = m_out_full;
        return s;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_in_pend = 0; m_ovr = 0; m_err = 0; m_out_full = 0;
        m_in_word = 16'h0; m_out_word = 16'h0;
    endtask

    task automatic check_side(input string tag);
        check({tag, ".in_valid"}, {15'b0, mbx_in_valid}, {15'b0, m_in_pend});
        if (m_in_pend) check({tag, ".in_data"}, mbx_in_data, m_in_word);
        check({tag, ".out_ready"}, {15'b0, mbx_out_ready}, {15'b0, !m_out_full});
    endtask

    task automatic hpi_write(input logic [1:0] a, input logic [15:0] w);
        @(negedge clk_clk);
        hpi_cs_n = 0; hpi_w_n = 0; hpi_addr = a; hpi_wdata = w;
        @(negedge clk_clk);
        hpi_cs_n = 1; hpi_w_n = 1;
        case (a)
            2'd0: begin m_mem[m_ptr] = w; m_ptr = (m_ptr + 1) % 256; end
            2'd1: begin if (m_in_pend) m_ovr = 1; m_in_pend = 1; m_in_word = w; end
            2'd2: m_ptr = (w / 2) % 256;
            default: ;
        endcase
    endtask

    task automatic hpi_read(input logic [1:0] a, output logic [15:0] obs);
        logic [15:0] exp;
        case (a)
            2'd0: begin exp = m_mem[m_ptr]; m_ptr = (m_ptr + 1) % 256; end
            2'd1: begin exp = m_out_word; m_out_full = 0; end
            2'd2: exp = 16'(m_ptr * 2);
            default: begin exp = model_status(); m_err = 0; m_ovr = 0; end
        endcase
        @(negedge clk_clk);
        hpi_cs_n = 0; hpi_r_n = 0; hpi_addr = a;
        @(negedge clk_clk);
        obs = hpi_rdata;
        hpi_cs_n = 1; hpi_r_n = 1;
        check($sformatf("read_reg%0d", a), obs, exp);
    endtask

    task automatic loc_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk_clk);
        loc_wr_en = 1; loc_wr_addr = a; loc_wr_data = d;
        #1;
        check("loc_ready", {15'b0, loc_wr_ready}, 16'h0001);
        m_mem[a] = d;
        @(negedge clk_clk);
        loc_wr_en = 0;
    endtask

    task automatic post(input logic [15:0] d);
        @(negedge clk_clk);
        mbx_out_valid = 1; mbx_out_data = d;
        #1;
        check("post_ready", {15'b0, mbx_out_ready}, {15'b0, !m_out_full});
        if (!m_out_full) begin m_out_full = 1; m_out_word = d; end
        @(negedge clk_clk);
        mbx_out_valid = 0;
    endtask

    task automatic consume();
        @(negedge clk_clk);
        mbx_in_ready = 1;
        @(negedge clk_clk);
        mbx_in_ready = 0;
        m_in_pend = 0;
    endtask

    logic [15:0] r;

    initial begin
        reset_reset_n = 0;
        hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1; hpi_addr = 0; hpi_wdata = 0;
        loc_wr_en = 1; loc_wr_addr = 0; loc_wr_data = 16'hFFFF;
        mbx_in_ready = 0; mbx_out_valid = 0; mbx_out_data = 0;
        model_reset();
        #12;
        // Reset state.
        check("rst.rdata", hpi_rdata, 16'h0000);
        check("rst.in_valid", {15'b0, mbx_in_valid}, 16'h0000);
        check("rst.in_data", mbx_in_data, 16'h0000);
        check("rst.out_ready", {15'b0, mbx_out_ready}, 16'h0001);
        check("rst.loc_ready", {15'b0, loc_wr_ready}, 16'h0000);
        loc_wr_en = 0;
        @(negedge clk_clk);
        reset_reset_n = 1;

        // Preload whole RAM from the local port so every later read has a known value.
        for (int i = 0; i < 256; i++) loc_write(8'(i), 16'($urandom));
        hpi_read(2'd2, r);
        check("rst.addr", r, 16'h0000);

        // Pointer auto-increment.
        hpi_write(2'd2, 16'h0010);
        hpi_write(2'd0, 16'h1111);
        hpi_write(2'd0, 16'h2222);
        hpi_write(2'd2, 16'h0010);
        hpi_read(2'd0, r); check("inc.d0", r, 16'h1111);
        hpi_read(2'd0, r); check("inc.d1", r, 16'h2222);
        hpi_read(2'd2, r); check("inc.addr", r, 16'h0014);

        // Pointer wrap.
        hpi_write(2'd2, 16'h01FE);
        hpi_write(2'd0, 16'hAAAA);
        hpi_write(2'd0, 16'hBBBB);
        hpi_read(2'd2, r); check("wrap.addr", r, 16'h0002);
        hpi_write(2'd2, 16'h01FE);
        hpi_read(2'd0, r); check("wrap.m255", r, 16'hAAAA);
        hpi_read(2'd0, r); check("wrap.m0", r, 16'hBBBB);

        // Collision: HPI DATA write at ptr=5 against a local write to 5.
        hpi_write(2'd2, 16'h000A);
        @(negedge clk_clk);
        hpi_cs_n = 0; hpi_w_n = 0; hpi_addr = 2'd0; hpi_wdata = 16'h5A5A;
        loc_wr_en = 1; loc_wr_addr = 8'd5; loc_wr_data = 16'h1234;
        #1;
        check("coll.loc_ready", {15'b0, loc_wr_ready}, 16'h0000);
        @(negedge clk_clk);
        hpi_cs_n = 1; hpi_w_n = 1; loc_wr_en = 0;
        m_mem[5] = 16'h5A5A; m_ptr = 6;
        hpi_write(2'd2, 16'h000A);
        hpi_read(2'd0, r); check("coll.m5", r, 16'h5A5A);
        loc_write(8'd5, 16'h1234);
        hpi_write(2'd2, 16'h000A);
        hpi_read(2'd0, r); check("coll.retry", r, 16'h1234);

        // Inbound mailbox and overrun.
        hpi_write(2'd1, 16'h00C5);
        check_side("mbi1");
        hpi_read(2'd3, r); check("mbi.st0", r, 16'h0002);
        hpi_write(2'd1, 16'h00C6);
        check("mbi.data", mbx_in_data, 16'h00C6);
        hpi_read(2'd3, r); check("mbi.st1", r, 16'h4002);
        hpi_read(2'd3, r); check("mbi.st2", r, 16'h0002);
        consume();
        check("mbi.valid_drop", {15'b0, mbx_in_valid}, 16'h0000);

        // Outbound mailbox.
        post(16'hBEEF);
        check("mbo.ready0", {15'b0, mbx_out_ready}, 16'h0000);
        hpi_read(2'd3, r); check("mbo.st", r, 16'h0001);
        post(16'h1234);
        hpi_read(2'd1, r); check("mbo.data", r, 16'hBEEF);
        hpi_read(2'd3, r); check("mbo.st_clr", r, 16'h0000);
        check("mbo.ready1", {15'b0, mbx_out_ready}, 16'h0001);

        // Held read strobe counts once.
        hpi_write(2'd2, 16'h0020);
        @(negedge clk_clk);
        hpi_cs_n = 0; hpi_r_n = 0; hpi_addr = 2'd0;
        repeat (10) @(negedge clk_clk);
        check("held.data", hpi_rdata, m_mem[16]);
        hpi_cs_n = 1; hpi_r_n = 1;
        m_ptr = 17;
        hpi_read(2'd2, r); check("held.addr", r, 16'h0022);

        // Illegal strobe combination.
        @(negedge clk_clk);
        hpi_cs_n = 0; hpi_r_n = 0; hpi_w_n = 0;
        @(negedge clk_clk);
        hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1;
        m_err = 1;
        hpi_read(2'd3, r); check("ill.st", r, 16'h8000);
        hpi_read(2'd3, r); check("ill.st_clr", r, 16'h0000);

        // Reset in the middle of a held read.
        loc_write(8'd3, 16'h1357);
        hpi_write(2'd2, 16'h0006);
        hpi_write(2'd1, 16'h0077);
        post(16'h4444);
        @(negedge clk_clk);
        hpi_cs_n = 0; hpi_r_n = 0; hpi_addr = 2'd0;
        @(negedge clk_clk);
        check("rmid.pre", hpi_rdata, 16'h1357);
        #2 reset_reset_n = 0;
        #1;
        check("rmid.rdata", hpi_rdata, 16'h0000);
        check("rmid.in_data", mbx_in_data, 16'h0000);
        hpi_cs_n = 1; hpi_r_n = 1;
        @(negedge clk_clk);
        reset_reset_n = 1;
        model_reset();
        check_side("rmid");
        hpi_read(2'd2, r); check("rmid.ptr", r, 16'h0000);
        hpi_read(2'd1, r); check("rmid.outreg", r, 16'h0000);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: hpi_write(2'd0, 16'($urandom));
                1: hpi_write(2'd2, 16'($urandom));
                2: hpi_write(2'd1, 16'($urandom));
                3: hpi_write(2'd3, 16'($urandom));
                4: hpi_read(2'd0, r);
                5: hpi_read(2'($urandom_range(1, 3)), r);
                6: loc_write(8'($urandom), 16'($urandom));
                7: post(16'($urandom));
                8: consume();
                default: begin
                    @(negedge clk_clk);
                    hpi_cs_n = 0; hpi_r_n = 0; hpi_w_n = 0;
                    @(negedge clk_clk);
                    hpi_cs_n = 1; hpi_r_n = 1; hpi_w_n = 1;
                    m_err = 1;
                end
            endcase
            check_side("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpi_responder.md
Name: hpi_responder

Overview:
- Synthesizable HPI target that answers the SoC's OTG-HPI PIO master: cs/addr/r/w strobes plus a 16-bit data bus in each direction.
- Stands in for the EZ-OTG host-port side, for loopback bring-up and for feeding keycode data without the USB chip.
- Contains a word RAM with an auto-incrementing address pointer, a bidirectional mailbox and a status register.
- A local fabric port lets on-chip logic inject RAM words and exchange mailbox words.

Parameters:
- RAM_WORDS, 256, depth of the internal 16-bit RAM (power of two).
- AW, 8, log2(RAM_WORDS).

Ports:
- clk_clk  in  1  system clock, shared with the SoC.
- reset_reset_n  in  1  asynchronous active-low reset.
- hpi_cs_n  in  1  chip select, active low.
- hpi_r_n  in  1  read strobe, active low.
- hpi_w_n  in  1  write strobe, active low.
- hpi_addr  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- hpi_wdata  in  16  write data from the SoC.
- hpi_rdata  out  16  registered read data to the SoC.
- loc_wr_en  in  1  local RAM write request.
- loc_wr_addr  in  AW  local word address.
- loc_wr_data  in  16  local write data.
- loc_wr_ready  out  1  local write accepted this cycle.
- mbx_in_data  out  16  mailbox word written by the SoC.
- mbx_in_valid  out  1  mailbox word pending.
- mbx_in_ready  in  1  local consumer takes the word.
- mbx_out_data  in  16  local word posted to the SoC.
- mbx_out_valid  in  1  post request.
- mbx_out_ready  out  1  outgoing mailbox empty.

Behaviour:
- Clock, reset: single clock domain, no synchronizers. Reset is asynchronous active-low.
- Reset values: hpi_rdata=0, ptr=0, mbx_in_valid=0, mbx_in_data=0, mbx_out reg=0, status flags=0, loc_wr_ready=0.
- Strobe qualification:
  - rd_act = !cs_n & !r_n & w_n.
  - wr_act = !cs_n & !w_n & r_n.
  - An access occurs only on the rising edge of the act signal (previous-cycle act=0, current=1), so a held strobe counts once.
  - cs_n & r_n & w_n all low: no access; sets sticky STATUS[15] ERR.
- Writes, committed in the first cycle of wr_act:
  - DATA: RAM[ptr] <= wdata, then ptr <= ptr+1.
  - MAILBOX: mbx_in_data <= wdata, mbx_in_valid <= 1. If a word was already pending it is overwritten and STATUS[14] OVR is set.
  - ADDRESS: ptr <= wdata[AW:1]. This is a byte address; bit 0 is ignored and upper bits are truncated.
  - STATUS: writes are ignored.
- Reads: hpi_rdata updates on the edge after the first rd_act cycle (1-cycle latency) and holds until the next read edge.
  - DATA: returns RAM[ptr], then ptr <= ptr+1.
  - MAILBOX: returns the mbx_out reg and clears STATUS[0].
  - ADDRESS: returns {ptr,1'b0} zero-extended.
  - STATUS: returns {ERR,OVR,12'b0,mbx_in_valid,out_full}; ERR and OVR clear on this read.
- Pointer wraps modulo RAM_WORDS (RAM_WORDS-1 -> 0).
- Mailbox handshakes:
  - mbx_in_valid drops in the cycle after mbx_in_valid & mbx_in_ready.
  - mbx_out_ready = !out_full. When mbx_out_valid & mbx_out_ready, the data is latched and out_full=1 (STATUS[0]).
  - SoC MAILBOX read and local post in the same cycle: the read returns the old value and clears out_full. The new post is not accepted that cycle because ready was 0.
- Local RAM port:
  - loc_wr_ready = loc_wr_en & !wr_edge_data (same-cycle combinational). The HPI DATA write always wins; local logic retries.
  - The RAM is single-write-port: the write mux is selected by priority.
- Reset mid-transfer: state clears immediately and the edge detectors return to 0. A strobe held through reset release therefore counts as a fresh access.

Decomposition:
- Package hpi_pkg:
  - Register-select constants: HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDR=2, HPI_STATUS=3.
  - STATUS bit indices.
- Sub-module hpi_strobe_edge: registers the act signals and emits the rd/wr edge pulses.
- The RAM is inferred inline.

Test Plan:
- Pointer auto-increment: write ADDRESS=0x0010, then DATA 0x1111, 0x2222, then ADDRESS=0x0010 and read DATA twice -> 0x1111, 0x2222. ADDRESS read -> 0x0014.
- Wrap: ADDRESS=0x01FE, write DATA 0xAAAA, 0xBBBB -> RAM[255]=0xAAAA, RAM[0]=0xBBBB, ptr=1.
- Mailbox in: SoC writes MAILBOX 0x00C5 with mbx_in_ready=0 -> mbx_in_valid=1, STATUS=0x0002. A second write 0x00C6 -> OVR. STATUS read -> 0x4002, next STATUS read -> 0x0002. mbx_in_ready pulse -> valid=0.
- Mailbox out: local posts 0xBEEF -> mbx_out_ready=0, STATUS bit0=1. SoC reads MAILBOX -> 0xBEEF, STATUS -> 0x0000, ready=1.
- Collision: loc_wr_en with addr 5 in the same cycle as an HPI DATA write at ptr=5 -> loc_wr_ready=0, RAM[5]=HPI data. Local retry next cycle -> accepted.
- Held strobe / illegal / reset:
  - r_n held low for 10 cycles -> ptr increments once.
  - r_n & w_n both low -> STATUS reads 0x8000.
  - Reset asserted mid-read -> hpi_rdata=0, ptr=0.
